// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched {pc, instr} entries with push, pop and flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  slots [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = slots[rd_ptr];

  // Pointers and occupancy; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) slots[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, issues instruction-memory reads and queues responses for decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH    = 32,
  parameter int unsigned            ADDRESS_WIDTH = 9,
  parameter int unsigned            QUEUE_DEPTH   = 4,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     redirect_valid,
  input  logic [DATA_WIDTH-1:0]    redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [DATA_WIDTH-1:0]    instr_pc
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned RW = CW + 1;

  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic [CW-1:0]         q_count;
  logic [RW-1:0]         reserved;
  logic                  q_full;
  logic                  q_empty;
  logic                  q_push;
  logic                  q_pop;
  fetch_entry_t          q_wdata;
  fetch_entry_t          q_head;

  // Slots already spoken for: queued entries plus the response still on its way.
  assign reserved  = RW'(q_count) + RW'(inflight);
  assign imem_req  = rst && !redirect_valid && !q_full && (reserved < RW'(QUEUE_DEPTH));
  assign imem_addr = imem_req ? fetch_pc[ADDRESS_WIDTH-1:0] : '0;

  assign q_push  = inflight && !redirect_valid;
  assign q_pop   = instr_valid && instr_ready;
  assign q_wdata = '{pc: XLEN'(inflight_pc), instr: XLEN'(imem_rdata)};

  assign instr_valid = !q_empty;
  assign instr       = instr_valid ? DATA_WIDTH'(q_head.instr) : '0;
  assign instr_pc    = instr_valid ? DATA_WIDTH'(q_head.pc)    : '0;

  // Fetch PC and single outstanding-request tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~DATA_WIDTH'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= DATA_WIDTH'(pc_incr(XLEN'(fetch_pc)));
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_valid),
    .wdata (q_wdata),
    .rdata (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run against an in-order stream model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        w_req;
  logic [8:0]  w_addr;
  logic [31:0] w_rdata = '0;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

  logic [31:0] mem [128];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9), .QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  instr_fetch #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9), .QUEUE_DEPTH(4), .RESET_PC(32'h1FC)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .instr_valid(w_valid),
    .instr_ready(w_ready), .instr(w_instr), .instr_pc(w_pc)
  );

  // Synchronous-read instruction memory shared by both instances.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr[8:2]];
    if (w_req)    w_rdata    <= mem[w_addr[8:2]];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
  endtask

  // Leaves the bench at the start of cycle 0 (first cycle with rst high).
  task automatic start_run();
    rst = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0; w_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    fill_mem();
    mem[0] = 32'h0050_0093;
    rst = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++;
      if ({imem_req, instr_valid, imem_addr} !== 11'b0) begin
        failures++; $display("FAIL reset_req_valid: req=%b valid=%b addr=%h want 0", imem_req, instr_valid, imem_addr);
      end
      checks++;
      if ({instr, instr_pc} !== 64'b0) begin
        failures++; $display("FAIL reset_instr: instr=%h pc=%h want 0", instr, instr_pc);
      end
    end
    rst = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 9'h0) begin
      failures++; $display("FAIL first_req: req=%b addr=%h want 1/000", imem_req, imem_addr);
    end
    tick(); #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL cycle1_valid: got %b want 0", instr_valid);
    end
    tick(); #1;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h0) begin
      failures++; $display("FAIL first_instr: valid=%b instr=%h pc=%h want 1/00500093/0", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 128; i++) mem[i] = 32'(i);
    start_run();
    instr_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (c >= 2) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (c - 2)) || instr !== 32'(c - 2)) begin
          failures++; $display("FAIL stream c=%0d: valid=%b pc=%h instr=%h want pc=%h instr=%h",
                               c, instr_valid, instr_pc, instr, 32'(4 * (c - 2)), 32'(c - 2));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    int ntx;
    fill_mem();
    start_run();
    exp_pc = 32'h0; ntx = 0;
    for (int c = 0; c < 40; c++) begin
      instr_ready = (c >= 10);
      #1;
      if (c < 10) begin
        checks++;
        if (imem_req !== (c < 4)) begin
          failures++; $display("FAIL bp_req c=%0d: got %b want %b", c, imem_req, (c < 4));
        end
        if (c >= 2) begin
          checks++;
          if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem[0]) begin
            failures++; $display("FAIL bp_hold c=%0d: valid=%b pc=%h instr=%h want pc 0 instr %h", c, instr_valid, instr_pc, instr, mem[0]);
          end
        end
      end else if (instr_valid && instr_ready) begin
        checks++;
        if (instr_pc !== exp_pc || instr !== mem[exp_pc[8:2]]) begin
          failures++; $display("FAIL bp_order: pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp_pc, mem[exp_pc[8:2]]);
        end
        exp_pc += 32'd4; ntx++;
      end
      tick();
    end
    checks++;
    if (ntx != 30) begin
      failures++; $display("FAIL bp_throughput: transfers=%0d want 30", ntx);
    end
  endtask

  task automatic test_redirect_flush();
    logic [31:0] exp_pc;
    fill_mem();
    start_run();
    for (int c = 0; c < 4; c++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h43; #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL flush_no_req: got %b want 0", imem_req);
    end
    tick(); redirect_valid = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 9'h40 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL flush_r1: req=%b addr=%h valid=%b want 1/040/0", imem_req, imem_addr, instr_valid);
    end
    tick(); #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL flush_r2: valid=%b want 0", instr_valid);
    end
    tick(); #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== mem[16]) begin
      failures++; $display("FAIL flush_r3: valid=%b pc=%h instr=%h want 1/40/%h", instr_valid, instr_pc, instr, mem[16]);
    end
    instr_ready = 1'b1;
    exp_pc = 32'h40;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (instr_valid) begin
        checks++;
        if (instr_pc !== exp_pc || instr !== mem[exp_pc[8:2]]) begin
          failures++; $display("FAIL flush_stream: pc=%h want %h", instr_pc, exp_pc);
        end
        exp_pc += 32'd4;
      end
      tick();
    end
  endtask

  task automatic test_redirect_handshake();
    logic [31:0] exp_pc;
    int seen8;
    fill_mem();
    start_run();
    instr_ready = 1'b1;
    exp_pc = 32'h0; seen8 = 0;
    for (int c = 0; c < 15; c++) begin
      redirect_valid = (c == 4); redirect_pc = 32'h100;
      #1;
      if (c == 4) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin
          failures++; $display("FAIL rh_transfer: valid=%b pc=%h want 1/8", instr_valid, instr_pc);
        end
      end
      if (instr_valid && instr_ready) begin
        checks++;
        if (instr_pc !== exp_pc || instr !== mem[exp_pc[8:2]]) begin
          failures++; $display("FAIL rh_order: pc=%h want %h", instr_pc, exp_pc);
        end
        if (instr_pc == 32'h8) seen8++;
        exp_pc += 32'd4;
      end
      if (redirect_valid) exp_pc = 32'h100;
      tick();
    end
    redirect_valid = 1'b0;
    checks++;
    if (seen8 != 1 || exp_pc <= 32'h100) begin
      failures++; $display("FAIL rh_once: pc8 seen %0d times, next exp %h; want 1 and > 100", seen8, exp_pc);
    end
  endtask

  task automatic test_wrap();
    fill_mem();
    start_run();
    w_ready = 1'b1; #1;
    checks++;
    if (w_req !== 1'b1 || w_addr !== 9'h1FC) begin
      failures++; $display("FAIL wrap_addr0: req=%b addr=%h want 1/1fc", w_req, w_addr);
    end
    tick(); #1;
    checks++;
    if (w_req !== 1'b1 || w_addr !== 9'h000) begin
      failures++; $display("FAIL wrap_addr1: req=%b addr=%h want 1/000", w_req, w_addr);
    end
    tick(); #1;
    checks++;
    if (w_valid !== 1'b1 || w_pc !== 32'h1FC || w_instr !== mem[127]) begin
      failures++; $display("FAIL wrap_pc0: valid=%b pc=%h instr=%h want 1/1fc/%h", w_valid, w_pc, w_instr, mem[127]);
    end
    tick(); #1;
    checks++;
    if (w_valid !== 1'b1 || w_pc !== 32'h200 || w_instr !== mem[0]) begin
      failures++; $display("FAIL wrap_pc1: valid=%b pc=%h instr=%h want 1/200/%h", w_valid, w_pc, w_instr, mem[0]);
    end
    tick();
    w_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    fill_mem();
    start_run();
    instr_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    rst = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL mid_reset_req: got %b want 0", imem_req);
    end
    tick(); #1;
    checks++;
    if ({instr_valid, instr, instr_pc, imem_req, imem_addr} !== 75'b0) begin
      failures++; $display("FAIL mid_reset_outputs: valid=%b instr=%h pc=%h req=%b addr=%h want all 0",
                           instr_valid, instr, instr_pc, imem_req, imem_addr);
    end
    tick(); rst = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 9'h0) begin
      failures++; $display("FAIL mid_restart_req: req=%b addr=%h want 1/000", imem_req, imem_addr);
    end
    tick(); tick(); #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem[0]) begin
      failures++; $display("FAIL mid_restart_instr: valid=%b pc=%h instr=%h want 1/0/%h", instr_valid, instr_pc, instr, mem[0]);
    end
    tick();
  endtask

  // Model: decode must see one unbroken PC stream, restarting at each redirect target.
  task automatic test_random();
    logic [31:0] exp_pc, hold_pc, hold_instr;
    logic        hold;
    int          ntx;
    fill_mem();
    start_run();
    exp_pc = 32'h0; hold = 1'b0; hold_pc = '0; hold_instr = '0; ntx = 0;
    for (int c = 0; c < 3000; c++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      #1;
      if (hold) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== hold_pc || instr !== hold_instr) begin
          failures++; $display("FAIL rnd_hold c=%0d: valid=%b pc=%h instr=%h want pc=%h instr=%h",
                               c, instr_valid, instr_pc, instr, hold_pc, hold_instr);
        end
      end
      if (!instr_valid) begin
        checks++;
        if (instr !== 32'h0 || instr_pc !== 32'h0) begin
          failures++; $display("FAIL rnd_idle c=%0d: instr=%h pc=%h want 0", c, instr, instr_pc);
        end
      end else if (instr_ready) begin
        checks++;
        if (instr_pc !== exp_pc || instr !== mem[exp_pc[8:2]]) begin
          failures++; $display("FAIL rnd_order c=%0d: pc=%h instr=%h want pc=%h instr=%h",
                               c, instr_pc, instr, exp_pc, mem[exp_pc[8:2]]);
        end
        exp_pc += 32'd4; ntx++;
      end
      checks++;
      if (dut.u_queue.push && dut.u_queue.full) begin
        failures++; $display("FAIL rnd_overflow c=%0d: push=%b full=%b want no push when full", c, dut.u_queue.push, dut.u_queue.full);
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      hold = instr_valid && !instr_ready && !redirect_valid;
      hold_pc = instr_pc; hold_instr = instr;
      tick();
    end
    redirect_valid = 1'b0;
    checks++;
    if (ntx < 1000) begin
      failures++; $display("FAIL rnd_progress: transfers=%0d want >= 1000", ntx);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_flush();
    test_redirect_handshake();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the decode/execute datapath (control unit, register file, sign extender). It owns the fetch program counter, issues word-aligned reads to a synchronous-read instruction memory, and buffers returned instructions with their PCs in a small queue. Decode consumes instructions over a valid/ready handshake. Branch and jump redirects arrive from execute and flush all in-flight and queued work.

## Interface
- DATA_WIDTH, 32, instruction and PC width
- ADDRESS_WIDTH, 9, instruction-memory byte-address width
- QUEUE_DEPTH, 4, instruction queue entries; power of two, at least 2
- RESET_PC, 0, fetch PC after reset; word aligned

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-low
- imem_req  out  1  read request this cycle
- imem_addr  out  ADDRESS_WIDTH  byte address; bits [1:0] always 0
- imem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after imem_req
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  DATA_WIDTH  restart PC; bits [1:0] ignored
- instr_valid  out  1  queue head is valid
- instr_ready  in  1  decode accepts the head
- instr  out  DATA_WIDTH  head instruction; 0 when instr_valid is low
- instr_pc  out  DATA_WIDTH  head PC; 0 when instr_valid is low

## Operation
- State:
  - fetch_pc
  - in-flight flag (request issued last cycle)
  - queue: count, read pointer, write pointer
- Request condition: imem_req = rst high && !redirect_valid && (count + inflight < QUEUE_DEPTH).
- On a request:
  - imem_addr = fetch_pc[ADDRESS_WIDTH-1:0].
  - fetch_pc advances by 4, modulo 2^DATA_WIDTH.
  - The PC of the request is recorded for its response.
- Response handling:
  - The cycle after a request, {recorded PC, imem_rdata} is pushed to the queue.
  - It is dropped if redirect_valid is high in that cycle.
- Address wrap: imem_addr wraps modulo 2^ADDRESS_WIDTH, while instr_pc carries the full fetch_pc.
- Handshake:
  - A transfer occurs when instr_valid && instr_ready.
  - instr and instr_pc hold stable while instr_valid && !instr_ready, unless a redirect occurs.
- Push and pop in the same cycle are allowed; count is unchanged.
- Push into a full queue is impossible because requests are reserved against count + inflight. Verification asserts this.
- Redirect has priority over everything in its cycle:
  - Queue is cleared (count and pointers set to 0).
  - The in-flight response is dropped.
  - No request is issued.
  - fetch_pc is set to {redirect_pc[DATA_WIDTH-1:2], 2'b00}.
  - A handshake transfer in the redirect cycle still counts as consumed.
- Reset mid-operation discards the queue, in-flight data and fetch_pc, identically to power-up.

## Timing
- Reset values while rst is low:
  - imem_req=0, imem_addr=0
  - instr_valid=0, instr=0, instr_pc=0
  - fetch_pc=RESET_PC, count=0, inflight=0
- Fetch latency:
  - First request in the first cycle with rst high (cycle 0).
  - Data arrives in cycle 1 and is written to the queue at the end of cycle 1.
  - instr_valid first rises in cycle 2. There is no bypass.
- Redirect latency: redirect in cycle R gives no request in R, request in R+1, and instr_valid with instr_pc = the new PC in R+3. instr_valid is low in R+1 and R+2.
- Throughput: one instruction per cycle with instr_ready held high, for QUEUE_DEPTH ≥ 2.
- Backpressure: the queue holds QUEUE_DEPTH entries, and imem_req falls in the cycle where count + inflight reaches QUEUE_DEPTH.

## Structure
- Package fetch_pkg:
  - fetch_entry_t struct {pc, instr}
  - INSTR_BYTES = 4
  - PC-increment helper function
- Sub-module fetch_queue:
  - circular buffer of fetch_entry_t with push, pop and flush
  - count output, full and empty flags, synchronous active-low reset
- Top-level instr_fetch holds fetch_pc, the in-flight tracking and the request logic.

## Test plan
- Reset and first fetch:
  - Stimulus: rst low for 3 cycles, then high, with instr_ready=1 and mem[0]=0x00500093.
  - Response: imem_req=0 and instr_valid=0 during reset. Cycle 0 has imem_req=1, imem_addr=0. Cycle 2 has instr=0x00500093, instr_pc=0.
- Streaming:
  - Stimulus: instr_ready=1 and mem[i]=i.
  - Response: one transfer per cycle from cycle 2 onward, with instr_pc=0,4,8,… and instr=0,1,2,… with no gaps.
- Backpressure:
  - Stimulus: instr_ready=0 from cycle 0 for 10 cycles, then 1.
  - Response: imem_req low after 4 reservations, and instr/instr_pc held at pc 0. After release, PCs 0,4,8,12,16 in order with no duplicates or gaps.
- Redirect flush:
  - Stimulus: with 3 queued entries and one request in flight, pulse redirect_valid with redirect_pc=0x43 in cycle R.
  - Response: no request in R, imem_addr=0x40 in R+1, instr_valid low in R+1 and R+2, instr_pc=0x40 in R+3, and no stale PC ever appears.
- Redirect with handshake:
  - Stimulus: redirect in the same cycle as a transfer of pc 0x8.
  - Response: pc 0x8 is consumed exactly once and the next valid PC is the redirect target.
- Wrap and reset mid-operation:
  - Wrap stimulus: RESET_PC=0x1FC.
  - Wrap response: imem_addr 0x1FC then 0x000, with instr_pc 0x1FC then 0x200.
  - Reset stimulus: assert rst low during streaming.
  - Reset response: outputs return to reset values the next cycle, and fetch restarts at RESET_PC.
